// File: rtl/obj_spawn_sched.sv
// rtl/obj_spawn_sched.sv - round-robin spawn scheduler for a pool of obj_ctl slots
// Optional reject path enabled with `define SPAWN_DROP_EN (default build: drop tied 0).
module obj_spawn_sched #(
  parameter int NOBJ  = 4,
  parameter int HOLD  = 16,
  parameter int CFG_W = 42
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [CFG_W-1:0]        cfg0,
  input  logic [CFG_W-1:0]        cfg1,
  input  logic                    clr,
  input  logic [NOBJ-1:0]         obj_vi,
  output logic [1:0]              gnt,
  output logic [1:0]              drop,
  output logic [NOBJ*CFG_W-1:0]   slot_cfg,
  output logic [NOBJ-1:0]         rst_obj,
  output logic [NOBJ-1:0]         slot_en,
  output logic                    busy,
  output logic [3:0]              free_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} fsm_e;
  typedef enum logic [1:0] {SL_FREE, SL_SPAWN, SL_LIVE} slot_e;

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int IW = (NOBJ > 1) ? $clog2(NOBJ) : 1;

  fsm_e             state_q, state_d;
  slot_e            slot_st_q [NOBJ];
  slot_e            slot_st_d [NOBJ];
  logic [CFG_W-1:0] cfg_q [NOBJ];
  logic [CFG_W-1:0] cfg_d [NOBJ];
  logic [NOBJ-1:0]  low_seen_q, low_seen_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rr_q, rr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       drop_q, drop_d;
  logic [NOBJ-1:0]  rst_obj_q, rst_obj_d;
  logic [NOBJ-1:0]  slot_en_q, slot_en_d;
  logic             busy_q, busy_d;
  logic [3:0]       free_cnt_q, free_cnt_d;

  logic             any_free;
  logic [IW-1:0]    free_idx;
  logic             win;

  // Winner: requester at the round-robin pointer if it is asking, else the other one
  assign win = req[rr_q] ? rr_q : ~rr_q;

  // Lowest-index FREE slot, judged on the registered state so a slot freed this cycle waits a cycle
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NOBJ - 1; i >= 0; i--) begin
      if (slot_st_q[i] == SL_FREE) begin
        any_free = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Next-state logic: reclaim filter, spawn FSM, kill-all override, registered output images
  always_comb begin
    state_d    = state_q;
    slot_st_d  = slot_st_q;
    cfg_d      = cfg_q;
    low_seen_d = low_seen_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    gnt_d      = 2'b00;
    drop_d     = 2'b00;
    rst_obj_d  = rst_obj_q;

    // A LIVE slot is reclaimed only after vi reads low on two consecutive samples
    for (int i = 0; i < NOBJ; i++) begin
      if (slot_st_q[i] == SL_LIVE) begin
        if (!obj_vi[i]) begin
          if (low_seen_q[i]) begin
            slot_st_d[i]  = SL_FREE;
            low_seen_d[i] = 1'b0;
          end else begin
            low_seen_d[i] = 1'b1;
          end
        end else begin
          low_seen_d[i] = 1'b0;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          if (any_free) begin
            state_d             = S_LOAD;
            gnt_d[win]          = 1'b1;
            idx_d               = free_idx;
            slot_st_d[free_idx] = SL_SPAWN;
            cfg_d[free_idx]     = win ? cfg1 : cfg0;
            rr_d                = ~win;
          end
`ifdef SPAWN_DROP_EN
          else if (drop_q == 2'b00) begin
            drop_d[win] = 1'b1;
            rr_d        = ~win;
          end
`endif
        end
      end
      S_LOAD: begin
        state_d          = S_HOLD;
        cnt_d            = CW'(HOLD - 1);
        rst_obj_d[idx_q] = 1'b1;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          rst_obj_d[idx_q]  = 1'b0;
          slot_st_d[idx_q]  = SL_LIVE;
          low_seen_d[idx_q] = 1'b0;
          state_d           = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Kill-all wins over everything except the stored configs
    if (clr) begin
      state_d    = S_IDLE;
      for (int i = 0; i < NOBJ; i++) slot_st_d[i] = SL_FREE;
      cfg_d      = cfg_q;
      idx_d      = idx_q;
      rr_d       = rr_q;
      cnt_d      = '0;
      low_seen_d = '0;
      rst_obj_d  = '0;
      gnt_d      = 2'b00;
      drop_d     = 2'b00;
    end

    busy_d     = (state_d != S_IDLE);
    free_cnt_d = '0;
    for (int i = 0; i < NOBJ; i++) begin
      slot_en_d[i] = (slot_st_d[i] == SL_LIVE);
      if (slot_st_d[i] == SL_FREE) free_cnt_d = free_cnt_d + 4'd1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < NOBJ; i++) begin
        slot_st_q[i] <= SL_FREE;
        cfg_q[i]     <= '0;
      end
      low_seen_q <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      gnt_q      <= 2'b00;
      drop_q     <= 2'b00;
      rst_obj_q  <= '0;
      slot_en_q  <= '0;
      busy_q     <= 1'b0;
      free_cnt_q <= 4'(NOBJ);
    end else begin
      state_q    <= state_d;
      slot_st_q  <= slot_st_d;
      cfg_q      <= cfg_d;
      low_seen_q <= low_seen_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      drop_q     <= drop_d;
      rst_obj_q  <= rst_obj_d;
      slot_en_q  <= slot_en_d;
      busy_q     <= busy_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  for (genvar g = 0; g < NOBJ; g++) begin : g_cfg
    assign slot_cfg[g*CFG_W +: CFG_W] = cfg_q[g];
  end

  assign gnt      = gnt_q;
  assign drop     = drop_q;
  assign rst_obj  = rst_obj_q;
  assign slot_en  = slot_en_q;
  assign busy     = busy_q;
  assign free_cnt = free_cnt_q;

endmodule

// File: tb/tb_obj_spawn_sched.sv
// tb/tb_obj_spawn_sched.sv - scoreboard bench for obj_spawn_sched
module tb_obj_spawn_sched;
  localparam int NOBJ  = 4;
  localparam int HOLD  = 16;
  localparam int CFG_W = 42;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [1:0]            req = 2'b00;
  logic [CFG_W-1:0]      cfg0 = '0;
  logic [CFG_W-1:0]      cfg1 = '0;
  logic                  clr = 1'b0;
  logic [NOBJ-1:0]       obj_vi = '1;
  logic [1:0]            gnt;
  logic [1:0]            drop;
  logic [NOBJ*CFG_W-1:0] slot_cfg;
  logic [NOBJ-1:0]       rst_obj;
  logic [NOBJ-1:0]       slot_en;
  logic                  busy;
  logic [3:0]            free_cnt;

  obj_spawn_sched #(.NOBJ(NOBJ), .HOLD(HOLD), .CFG_W(CFG_W)) dut (
    .clk(clk), .rst(rst), .req(req), .cfg0(cfg0), .cfg1(cfg1), .clr(clr),
    .obj_vi(obj_vi), .gnt(gnt), .drop(drop), .slot_cfg(slot_cfg),
    .rst_obj(rst_obj), .slot_en(slot_en), .busy(busy), .free_cnt(free_cnt)
  );

  typedef struct {
    int               rq;
    int               slot;
    logic [CFG_W-1:0] cfg;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   chk_slot = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [CFG_W-1:0] mk_cfg(int lifes, int xs, int ys, int xam, int yam, int x, int y);
    return {6'(lifes), 8'(xs), 8'(ys), 1'(xam), 1'(yam), 9'(x), 9'(y)};
  endfunction

  function automatic exp_t mk_exp(int rq, int slot, logic [CFG_W-1:0] cfg);
    exp_t e;
    e.rq = rq; e.slot = slot; e.cfg = cfg;
    return e;
  endfunction

  // Grant monitor: pops the scoreboard on every grant, then checks the slot's rst_obj next cycle
  always @(negedge clk) begin
    exp_t e;
    logic [NOBJ-1:0] oh;
    logic [1:0] g_exp;
    if (chk_slot >= 0) begin
      oh = '0;
      oh[chk_slot] = 1'b1;
      tests++;
      if (rst_obj !== oh) begin
        fails++;
        $display("FAIL slot_alloc rst_obj=%b expected=%b", rst_obj, oh);
      end
      chk_slot = -1;
    end
    if (gnt !== 2'b00) begin
      tests++;
      if (drop !== 2'b00) begin
        fails++;
        $display("FAIL gnt_drop_overlap gnt=%b drop=%b expected drop=00", gnt, drop);
      end
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_gnt gnt=%b expected none at cycle %0d", gnt, cyc);
      end else begin
        e = sb.pop_front();
        g_exp = '0;
        g_exp[e.rq] = 1'b1;
        tests++;
        if (gnt !== g_exp) begin
          fails++;
          $display("FAIL gnt_id gnt=%b expected=%b", gnt, g_exp);
        end
        tests++;
        if (slot_cfg[e.slot*CFG_W +: CFG_W] !== e.cfg) begin
          fails++;
          $display("FAIL slot_cfg[%0d]=%h expected=%h", e.slot, slot_cfg[e.slot*CFG_W +: CFG_W], e.cfg);
        end
        chk_slot = e.slot;
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_gnt(output int c, output bit ok);
    ok = 1'b0;
    c = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt !== 2'b00) begin
        ok = 1'b1;
        c = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = 2'b00; clr = 1'b0; obj_vi = '1;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    chk_slot = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (free_cnt !== 4'd4) begin fails++; $display("FAIL reset_free_cnt got=%0d expected=4", free_cnt); end
    tests++;
    if ({gnt, drop, busy} !== 5'b0) begin fails++; $display("FAIL reset_ctl gnt=%b drop=%b busy=%b expected 0", gnt, drop, busy); end
    tests++;
    if ({rst_obj, slot_en} !== '0) begin fails++; $display("FAIL reset_slots rst_obj=%b slot_en=%b expected 0", rst_obj, slot_en); end
    tests++;
    if (slot_cfg !== '0) begin fails++; $display("FAIL reset_slot_cfg got=%h expected 0", slot_cfg); end
    rst = 1'b1;
  endtask

  task automatic test_first_spawn();
    logic [CFG_W-1:0] c0;
    int bad;
    c0 = mk_cfg(3, 4, 0, 1, 0, 100, 200);
    cfg0 = c0;
    req = 2'b01;
    sb.push_back(mk_exp(0, 0, c0));
    @(negedge clk);
    tests++;
    if (gnt !== 2'b01 || busy !== 1'b1 || free_cnt !== 4'd3) begin
      fails++; $display("FAIL first_gnt gnt=%b busy=%b free_cnt=%0d expected 01/1/3", gnt, busy, free_cnt);
    end
    req = 2'b00;
    bad = 0;
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      if (rst_obj !== 4'b0001 || slot_en !== 4'b0000) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL first_hold bad_cycles=%0d expected 0", bad); end
    @(negedge clk);
    tests++;
    if (rst_obj !== 4'b0000 || slot_en !== 4'b0001 || busy !== 1'b0 || free_cnt !== 4'd3) begin
      fails++; $display("FAIL first_live rst_obj=%b slot_en=%b busy=%b free_cnt=%0d expected 0000/0001/0/3", rst_obj, slot_en, busy, free_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [CFG_W-1:0] ca, cb;
    int c, prev, gseen, dseen;
    bit ok;
    do_reset();
    ca = mk_cfg(1, 2, 3, 0, 1, 10, 20);
    cb = mk_cfg(5, 6, 7, 1, 1, 300, 400);
    cfg0 = ca; cfg1 = cb;
    sb.push_back(mk_exp(0, 0, ca));
    sb.push_back(mk_exp(1, 1, cb));
    sb.push_back(mk_exp(0, 2, ca));
    sb.push_back(mk_exp(1, 3, cb));
    req = 2'b11;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(c, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL b2b_timeout grant=%0d got none expected gnt", k); end
      else if (k > 0 && (c - prev) != HOLD + 2) begin
        fails++; $display("FAIL b2b_spacing got=%0d expected=%0d", c - prev, HOLD + 2);
      end
      prev = c;
    end
    step(HOLD + 1);
    gseen = 0; dseen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt !== 2'b00) gseen++;
      if (drop !== 2'b00) dseen++;
    end
    tests++;
    if (gseen != 0 || busy !== 1'b0 || free_cnt !== 4'd0 || slot_en !== 4'b1111) begin
      fails++; $display("FAIL full_idle gnts=%0d busy=%b free_cnt=%0d slot_en=%b expected 0/0/0/1111", gseen, busy, free_cnt, slot_en);
    end
`ifndef SPAWN_DROP_EN
    tests++;
    if (dseen != 0) begin fails++; $display("FAIL no_drop_build drops=%0d expected 0", dseen); end
`endif
  endtask

  task automatic test_reclaim();
    logic [CFG_W-1:0] cc;
    cc = mk_cfg(2, 1, 1, 0, 0, 50, 60);
    cfg0 = cc;
    req = 2'b01;
    sb.push_back(mk_exp(0, 2, cc));
    @(negedge clk);
    obj_vi[2] = 1'b0;
    step(2);
    tests++;
    if (slot_en !== 4'b1011 || free_cnt !== 4'd1 || gnt !== 2'b00) begin
      fails++; $display("FAIL reclaim slot_en=%b free_cnt=%0d gnt=%b expected 1011/1/00", slot_en, free_cnt, gnt);
    end
    @(negedge clk);
    tests++;
    if (gnt !== 2'b01 || free_cnt !== 4'd0) begin
      fails++; $display("FAIL reclaim_gnt gnt=%b free_cnt=%0d expected 01/0", gnt, free_cnt);
    end
    obj_vi[2] = 1'b1;
    req = 2'b00;
    step(HOLD + 2);
    tests++;
    if (slot_en !== 4'b1111) begin fails++; $display("FAIL reclaim_live slot_en=%b expected 1111", slot_en); end
  endtask

  task automatic test_glitch();
    obj_vi[1] = 1'b0;
    @(negedge clk);
    obj_vi[1] = 1'b1;
    step(3);
    tests++;
    if (slot_en !== 4'b1111 || free_cnt !== 4'd0) begin
      fails++; $display("FAIL glitch_single slot_en=%b free_cnt=%0d expected 1111/0", slot_en, free_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      obj_vi[1] = i[0];
      @(negedge clk);
    end
    obj_vi[1] = 1'b1;
    step(2);
    tests++;
    if (slot_en !== 4'b1111) begin fails++; $display("FAIL glitch_alt slot_en=%b expected 1111", slot_en); end
  endtask

  task automatic test_pool_wait(output logic [CFG_W-1:0] cd);
    int gseen, dseen, consec, badv, c;
    logic prev_d;
    bit ok;
    cd = mk_cfg(7, 9, 9, 1, 0, 111, 222);
    cfg1 = cd;
    req = 2'b10;
    gseen = 0; dseen = 0; consec = 0; badv = 0; prev_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt !== 2'b00) gseen++;
      if (drop !== 2'b00) begin
        dseen++;
        if (drop !== 2'b10) badv++;
        if (prev_d) consec++;
      end
      prev_d = (drop !== 2'b00);
    end
    tests++;
    if (gseen != 0) begin fails++; $display("FAIL full_wait_gnt gnts=%0d expected 0", gseen); end
    tests++;
`ifdef SPAWN_DROP_EN
    if (dseen != 5 || consec != 0 || badv != 0) begin
      fails++; $display("FAIL drop_pulses count=%0d consec=%0d wrong_id=%0d expected 5/0/0", dseen, consec, badv);
    end
`else
    if (dseen != 0) begin fails++; $display("FAIL drop_tied count=%0d expected 0", dseen); end
`endif
    sb.push_back(mk_exp(1, 3, cd));
    obj_vi[3] = 1'b0;
    wait_gnt(c, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL wait_gnt_timeout got none expected gnt[1]"); end
    req = 2'b00;
    obj_vi[3] = 1'b1;
  endtask

  task automatic test_clr(input logic [CFG_W-1:0] cd);
    int c;
    bit ok;
    step(6);
    tests++;
    if (rst_obj !== 4'b1000 || busy !== 1'b1) begin fails++; $display("FAIL clr_pre rst_obj=%b busy=%b expected 1000/1", rst_obj, busy); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tests++;
    if (rst_obj !== 4'b0000 || slot_en !== 4'b0000 || free_cnt !== 4'd4 || busy !== 1'b0) begin
      fails++; $display("FAIL clr_effect rst_obj=%b slot_en=%b free_cnt=%0d busy=%b expected 0/0/4/0", rst_obj, slot_en, free_cnt, busy);
    end
    tests++;
    if (slot_cfg[3*CFG_W +: CFG_W] !== cd) begin
      fails++; $display("FAIL clr_cfg_kept got=%h expected=%h", slot_cfg[3*CFG_W +: CFG_W], cd);
    end
    req = 2'b01; clr = 1'b1;
    @(negedge clk);
    tests++;
    if (gnt !== 2'b00) begin fails++; $display("FAIL clr_suppress gnt=%b expected 00", gnt); end
    clr = 1'b0;
    sb.push_back(mk_exp(0, 0, cfg0));
    wait_gnt(c, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL clr_regrant_timeout got none expected gnt[0]"); end
    req = 2'b00;
  endtask

  task automatic test_async_reset();
    step(5);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({rst_obj, slot_en, gnt, drop, busy} !== '0 || free_cnt !== 4'd4) begin
      fails++; $display("FAIL async_reset rst_obj=%b slot_en=%b gnt=%b busy=%b free_cnt=%0d expected all 0, free 4", rst_obj, slot_en, gnt, busy, free_cnt);
    end
    tests++;
    if (slot_cfg !== '0) begin fails++; $display("FAIL async_reset_cfg got=%h expected 0", slot_cfg); end
    @(negedge clk);
    rst = 1'b1;
    step(2);
  endtask

  initial begin
    logic [CFG_W-1:0] cd;
    test_reset();
    test_first_spawn();
    test_back_to_back();
    test_reclaim();
    test_glitch();
    test_pool_wait(cd);
    test_clr(cd);
    test_async_reset();
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_left pending=%0d expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
